// File: rtl/if_prefetch_stage_pkg.sv
// Shared types and constants for the instruction prefetch stage.
// Holds boot address, PC increment, FSM states and FIFO entry layout.
package if_prefetch_stage_pkg;

    localparam logic [31:0] IF_BOOT_ADDR = 32'h0000_8000;
    localparam logic [31:0] IF_PC_INCR   = 32'd4;
    localparam int unsigned IF_CNT_W     = 3;

    typedef enum logic [1:0] {
        IF_BOOT,
        IF_RUN,
        IF_HALT
    } if_state;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small registered FIFO of fetched {err, pc, instr} entries.
// Ports: push/entry in, pop, flush; head out with count, empty, full.
module if_fifo
    import if_prefetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  if_entry_t           entry_i,
    input  logic                pop_i,
    input  logic                flush_i,
    output if_entry_t           head_o,
    output logic [IF_CNT_W-1:0] count_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if_entry_t           mem_q [DEPTH];
    if_entry_t           mem_d [DEPTH];
    logic [AW-1:0]       wr_q, wr_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [IF_CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_q] = entry_i;
                wr_d        = inc(wr_q);
            end
            if (pop_i) begin
                rd_d = inc(rd_q);
            end
            cnt_d = cnt_q + IF_CNT_W'(push_i)
                          - IF_CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == IF_CNT_W'(DEPTH));

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch front-end: issues word requests, buffers responses,
// hands {instr, pc} to decode over valid/ready, restarts on redirect.
// Ports: instr_req/addr/gnt/rvalid/rdata memory side, redirect_i/pc_i,
// instr_valid/ready/instr/pc to decode, busy_o.
// Optional IF_ERR_EN adds instr_err_i/instr_err_o and a HALT state.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BOOT_ADDR = IF_BOOT_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
`ifdef IF_ERR_EN
    input  logic        instr_err_i,
    output logic        instr_err_o,
`endif
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        busy_o
);

    localparam logic [IF_CNT_W:0] DEPTH_L = (IF_CNT_W + 1)'(DEPTH);

    if_state             state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [31:0]         resp_pc_q, resp_pc_d;
    logic [31:0]         addr_q, addr_d;
    logic                req_q, req_d;
    logic                stale_q, stale_d;
    logic [IF_CNT_W-1:0] pend_q, pend_d;
    logic [IF_CNT_W-1:0] disc_q, disc_d;

    logic                gnt_ok, rvalid_ok, drop;
    logic                push, pop, resp_err;
    logic [IF_CNT_W-1:0] cnt_nxt;
    logic [IF_CNT_W:0]   occ;
    logic [31:0]         target;
    if_entry_t           entry, head;
    logic [IF_CNT_W-1:0] fifo_cnt;
    logic                fifo_empty, fifo_full;

`ifdef IF_ERR_EN
    assign resp_err = instr_err_i;
`else
    assign resp_err = 1'b0;
`endif

    assign target = redirect_pc_i & ~32'd3;

    always_comb begin
        gnt_ok    = instr_gnt_i && req_q;
        // rvalid with nothing outstanding is a protocol error: ignore it
        rvalid_ok = instr_rvalid_i && (pend_q != '0);
        drop      = rvalid_ok && (disc_q != '0);
        push      = rvalid_ok && !drop && !redirect_i
                    && (!fifo_full || pop);
        pop       = !fifo_empty && instr_ready_i && !redirect_i;

        entry.err   = resp_err;
        entry.pc    = resp_pc_q;
        entry.instr = resp_err ? '0 : instr_rdata_i;

        pend_d = pend_q + IF_CNT_W'(gnt_ok)
                        - IF_CNT_W'(rvalid_ok);

        // a held request granted after a redirect fetched a stale address
        disc_d  = disc_q + IF_CNT_W'(gnt_ok && stale_q)
                         - IF_CNT_W'(drop);
        stale_d = gnt_ok ? 1'b0 : stale_q;

        fetch_pc_d = fetch_pc_q;
        if (gnt_ok && !stale_q) begin
            fetch_pc_d = fetch_pc_q + IF_PC_INCR;
        end
        resp_pc_d = push ? resp_pc_q + IF_PC_INCR : resp_pc_q;

        state_d = state_q;
        unique case (state_q)
            IF_BOOT: state_d = IF_RUN;
            IF_RUN: begin
                if (push && resp_err) begin
                    state_d = IF_HALT;
                end
            end
`ifdef IF_ERR_EN
            IF_HALT: state_d = IF_HALT;
`endif
            default: state_d = IF_RUN;
        endcase

        if (redirect_i) begin
            // every outstanding response, incl. this cycle's grant, is stale
            disc_d     = pend_d;
            fetch_pc_d = target;
            resp_pc_d  = target;
            state_d    = IF_RUN;
            if (req_q && !gnt_ok) begin
                stale_d = 1'b1;
            end
        end

        cnt_nxt = redirect_i ? '0
                : fifo_cnt + IF_CNT_W'(push) - IF_CNT_W'(pop);
        occ     = {1'b0, cnt_nxt} + {1'b0, pend_d};

        req_d  = 1'b0;
        addr_d = addr_q;
        if (req_q && !gnt_ok) begin
            req_d = 1'b1;
        end else if (state_d == IF_RUN && occ < DEPTH_L) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IF_BOOT;
            fetch_pc_q <= BOOT_ADDR;
            resp_pc_q  <= BOOT_ADDR;
            addr_q     <= BOOT_ADDR;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
            pend_q     <= '0;
            disc_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            stale_q    <= stale_d;
            pend_q     <= pend_d;
            disc_q     <= disc_d;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .entry_i (entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .head_o  (head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign instr_req_o   = req_q;
    assign instr_addr_o  = addr_q;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head.err ? '0 : head.instr;
    assign instr_pc_o    = head.pc;
`ifdef IF_ERR_EN
    assign instr_err_o   = head.err;
`endif
    assign busy_o = req_q || (pend_q != '0) || (disc_q != '0);

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed self-checking bench for if_prefetch_stage with an in-order
// memory responder; define IF_ERR_EN to also exercise the fault path.
module tb_if_prefetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        busy_o;
    logic        err_mon;
`ifdef IF_ERR_EN
    logic        instr_err_i = 1'b0;
    logic        instr_err_o;
    assign err_mon = instr_err_o;
`else
    assign err_mon = 1'b0;
`endif

    if_prefetch_stage dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
`ifdef IF_ERR_EN
        .instr_err_i    (instr_err_i),
        .instr_err_o    (instr_err_o),
`endif
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          errors = 0;
    int          checks = 0;
    int          gcount = 0;
    int          g0;
    bit          found;
    bit          gnt_en = 1'b1;
    bit          rsp_en = 1'b1;
    bit          err_mode = 1'b0;
    logic [31:0] old_addr;
    logic [31:0] q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_in[$];
    logic [31:0] got_err[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h8000) return 32'h0000_0013;
        if (a == 32'h8004) return 32'h0010_0093;
        return {16'hABCD, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem();
        instr_gnt_i    = gnt_en && instr_req_o;
        instr_rvalid_i = rsp_en && (q.size() > 0);
        instr_rdata_i  = instr_rvalid_i ? word(q[0]) : 32'h0;
`ifdef IF_ERR_EN
        instr_err_i    = instr_rvalid_i && err_mode
                         && (q[0] == 32'h8004);
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!rst_i) begin
            if (instr_req_o && instr_gnt_i) begin
                q.push_back(instr_addr_o);
                gcount++;
            end
            if (instr_rvalid_i && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (instr_valid_o && instr_ready_i && !redirect_i) begin
                got_pc.push_back(instr_pc_o);
                got_in.push_back(instr_o);
                got_err.push_back({31'd0, err_mon});
            end
        end
        @(negedge clk_i);
        drive_mem();
    endtask

    task automatic wait_got(input int n, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (got_pc.size() >= n) break;
            tick();
        end
        chk("deliveries", got_pc.size(), n);
    endtask

    task automatic clear_got();
        got_pc.delete();
        got_in.delete();
        got_err.delete();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        clear_got();
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        tick();
        redirect_i    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_req", instr_req_o, 0);
        chk("rst_addr", instr_addr_o, 32'h8000);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", instr_pc_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b0;

        tick();
        chk("boot_req", instr_req_o, 1);
        chk("boot_addr", instr_addr_o, 32'h8000);
        tick();
        chk("lat_n1_valid", instr_valid_o, 0);
        tick();
        chk("lat_n2_valid", instr_valid_o, 1);
        chk("lat_n2_instr", instr_o, 32'h0000_0013);
        chk("lat_n2_pc", instr_pc_o, 32'h8000);

        repeat (6) tick();
        chk("stall_grants", gcount, 2);
        chk("stall_req", instr_req_o, 0);
        chk("stall_head", instr_pc_o, 32'h8000);
        chk("stall_busy", busy_o, 0);

        instr_ready_i = 1'b1;
        wait_got(2, 20);
        if (got_pc.size() >= 2) begin
            chk("drain_pc0", got_pc[0], 32'h8000);
            chk("drain_pc1", got_pc[1], 32'h8004);
            chk("drain_in0", got_in[0], 32'h0000_0013);
            chk("drain_in1", got_in[1], 32'h0010_0093);
        end

        instr_ready_i = 1'b0;
        repeat (8) tick();
        chk("full_req", instr_req_o, 0);
        chk("full_busy", busy_o, 0);
        chk("full_valid", instr_valid_o, 1);

        rsp_en = 1'b0;
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        tick();
        chk("pend_req", instr_req_o, 0);
        chk("pend_busy", busy_o, 1);
        chk("pend_valid", instr_valid_o, 1);
        redirect_to(32'h0000_1236);
        chk("rd1_valid", instr_valid_o, 0);
        chk("rd1_req", instr_req_o, 1);
        chk("rd1_addr", instr_addr_o, 32'h1234);
        rsp_en = 1'b1;
        instr_ready_i = 1'b1;
        wait_got(2, 30);
        if (got_pc.size() >= 2) begin
            chk("rd1_pc0", got_pc[0], 32'h1234);
            chk("rd1_pc1", got_pc[1], 32'h1238);
            chk("rd1_in0", got_in[0], 32'hABCD_1234);
        end

        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_gnt_i && instr_rvalid_i) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rd2_coincide", {31'd0, found}, 1);
        redirect_to(32'h0000_2000);
        chk("rd2_valid", instr_valid_o, 0);
        wait_got(2, 30);
        if (got_pc.size() >= 2) begin
            chk("rd2_pc0", got_pc[0], 32'h2000);
            chk("rd2_pc1", got_pc[1], 32'h2004);
        end

        redirect_to(32'hFFFF_FFFC);
        wait_got(2, 30);
        if (got_pc.size() >= 2) begin
            chk("wrap_pc0", got_pc[0], 32'hFFFF_FFFC);
            chk("wrap_pc1", got_pc[1], 32'h0000_0000);
            chk("wrap_in1", got_in[1], 32'hABCD_0000);
        end

        gnt_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_req_o && !instr_gnt_i) break;
            tick();
        end
        chk("held_req", instr_req_o, 1);
        old_addr = instr_addr_o;
        redirect_to(32'h0000_3000);
        chk("held_req_after", instr_req_o, 1);
        chk("held_addr0", instr_addr_o, old_addr);
        tick();
        chk("held_addr1", instr_addr_o, old_addr);
        gnt_en = 1'b1;
        wait_got(2, 40);
        if (got_pc.size() >= 2) begin
            chk("held_pc0", got_pc[0], 32'h3000);
            chk("held_pc1", got_pc[1], 32'h3004);
        end

        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", instr_valid_o, 0);
        chk("mid_rst_req", instr_req_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_pc", instr_pc_o, 0);
        q.delete();
        clear_got();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
`ifdef IF_ERR_EN
        instr_err_i    = 1'b0;
        err_mode       = 1'b1;
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_got(2, 20);
        if (got_pc.size() >= 2) begin
            chk("re_pc0", got_pc[0], 32'h8000);
            chk("re_pc1", got_pc[1], 32'h8004);
            chk("re_in0", got_in[0], 32'h0000_0013);
            chk("re_err0", got_err[0], 0);
`ifdef IF_ERR_EN
            chk("err_in1", got_in[1], 32'h0);
            chk("err_flag1", got_err[1], 1);
`else
            chk("re_in1", got_in[1], 32'h0010_0093);
`endif
        end

`ifdef IF_ERR_EN
        repeat (8) tick();
        g0 = gcount;
        repeat (6) tick();
        chk("halt_grants", gcount, g0);
        chk("halt_req", instr_req_o, 0);
        err_mode = 1'b0;
        redirect_to(32'h0000_9000);
        wait_got(1, 30);
        if (got_pc.size() >= 1) begin
            chk("resume_pc", got_pc[0], 32'h9000);
            chk("resume_err", got_err[0], 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Instruction fetch front-end of the core. It sits directly upstream of the decode stage, which consumes its instruction/PC pair and maps it to the opcode, alu_op, op_a_sel, op_b_sel and imm_b_sel values.
- Issues word requests to instruction memory and buffers the returned words in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Restarts from a new PC on a redirect (JAL, JALR, taken BRANCH) from the PC ALU.

Parameters:
- DEPTH, 2, FIFO entries; also the cap on (FIFO occupancy + outstanding requests). Legal range 1..4.
- BOOT_ADDR, 32'h0000_8000, first fetch address after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  word-aligned fetch address.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  read data valid; responses return in request order.
- instr_rdata_i  in  32  read data.
- redirect_i  in  1  flush and restart, one-cycle pulse from the PC ALU.
- redirect_pc_i  in  32  restart target.
- instr_valid_o  out  1  FIFO head valid to decode.
- instr_ready_i  in  1  decode accepts the head.
- instr_o  out  32  head instruction.
- instr_pc_o  out  32  head PC.
- busy_o  out  1  request pending or discard outstanding.

Behaviour:
- Reset (async, rst_i=1):
  - Outputs: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, instr_pc_o=0, busy_o=0.
  - Internal: fetch_pc=BOOT_ADDR, FIFO empty, pending=0, discard=0, state=BOOT.
- FSM:
  - BOOT: lasts one cycle after reset release, then RUN.
  - RUN: normal fetching.
  - HALT: only with IF_ERR_EN.
- Request rule, evaluated in RUN:
  - instr_req_o=1 when count + pending < DEPTH, or when a request is already held.
  - Once asserted, instr_req_o and instr_addr_o hold stable until instr_gnt_i.
  - On grant: pending+1 and fetch_pc+4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Response rule:
  - On instr_rvalid_i with discard>0: the word is dropped and discard-1.
  - Otherwise the word is pushed to the FIFO with its PC; PCs are tracked in grant order.
  - Each rvalid decrements pending.
  - rvalid with pending=0 is a protocol violation; the block ignores it.
- Latency: gnt in cycle N, rvalid earliest N+1, instr_valid_o=1 in N+2 because the FIFO is registered.
- Output handshake:
  - instr_valid_o = FIFO not empty.
  - The head is popped when instr_valid_o && instr_ready_i.
  - instr_o and instr_pc_o stay stable while valid && !ready.
- Full FIFO and simultaneous events:
  - FIFO full and rvalid cannot coincide, because of the request rule.
  - Push and pop in the same cycle keep the count unchanged.
- Redirect (redirect_i=1, highest priority):
  - The FIFO is cleared and any pop in the same cycle is ignored.
  - instr_valid_o=0 from the next cycle.
  - discard = pending + (instr_rvalid_i ? -1 : 0) + (instr_gnt_i ? 1 : 0), so the same-cycle rvalid is also dropped.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - An ungranted held request keeps its old address until granted, is counted into discard, and the new target is requested after that grant.
  - Back-to-back redirects: the last one wins; discard accumulates.
- busy_o = instr_req_o || pending != 0 || discard != 0.
- Reset mid-transaction: all state clears immediately. The memory side must also be reset.

Optional Feature:
- Macro: IF_ERR_EN.
- Defined:
  - Adds port instr_err_i (in, 1, qualifies rvalid) and port instr_err_o (out, 1, head entry faulted).
  - A faulted response is pushed with its error flag set and no instr data (instr_o=0 when instr_err_o=1).
  - The FSM enters HALT: no new requests, but outstanding responses are still absorbed.
  - Only redirect_i leaves HALT, returning to RUN.
- Undefined: neither port exists, the HALT state is absent, and every response is accepted as good.

Decomposition:
- Shared package gets:
  - IF_BOOT_ADDR = 32'h0000_8000.
  - IF_PC_INCR = 4.
  - typedef enum logic [1:0] if_state {IF_BOOT, IF_RUN, IF_HALT}.
- One natural sub-module: if_fifo.
  - Parameterised DEPTH, entry = {err, pc[31:0], instr[31:0]}.
  - Push/pop/flush; exposes count, empty, full.

Test Plan:
- Reset release, memory grants at once and returns rvalid the next cycle with words 0x00000013 and 0x00100093 -> addresses 0x8000 then 0x8004; instr_valid_o rises 2 cycles after the first gnt with instr_o=0x00000013, instr_pc_o=0x8000.
- instr_ready_i=0 for 6 cycles with DEPTH=2 -> exactly 2 grants outstanding/buffered and instr_req_o=0; head stays 0x8000; on ready=1 the PCs drain in order 0x8000 then 0x8004.
- Redirect to 0x0000_1236 while 1 request is pending and the FIFO holds 1 entry -> FIFO cleared, pending response dropped, next delivered instr_pc_o=0x1234.
- Redirect in the same cycle as gnt and rvalid -> both responses dropped (discard count correct); first delivered PC = target.
- Redirect to 0xFFFF_FFFC -> successive PCs 0xFFFF_FFFC then 0x0000_0000.
- IF_ERR_EN: error on the 0x8004 response -> 0x8000 delivered normally; 0x8004 has instr_err_o=1; no further requests until a redirect to 0x9000 resumes fetching at 0x9000.
